// File: rtl/accel_bus_arbiter.sv
// Shared RAM bus arbiter for the FFT/FIR/IIR accelerators.
// Define ARB_FIXED_PRIORITY_EN for fixed FFT > FIR > IIR priority.
module accel_bus_arbiter #(
    parameter int unsigned QUANTUM     = 16,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fft_req,
    input  logic       fir_req,
    input  logic       iir_req,
    input  logic       bus_busy,
    output logic       fft_enable,
    output logic       fir_enable,
    output logic       iir_enable,
    output logic [1:0] grant_id,
    output logic       release_pulse
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_FFT  = 2'd1;
    localparam logic [1:0] ID_FIR  = 2'd2;
    localparam logic [1:0] ID_IIR  = 2'd3;

    localparam logic [7:0] Q_LAST = 8'(QUANTUM - 1);
    localparam logic [3:0] T_LAST = 4'(TURN_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] r_gid;
    logic [1:0] r_last;
    logic [2:0] r_en;
    logic [7:0] r_qcnt;
    logic [3:0] r_tcnt;
    logic       r_pulse;

    logic [1:0] w_win;
    logic       w_own_req;
    logic       w_other;
    logic       w_qend;
    logic       w_rel;

    always_comb begin
        w_win = ID_NONE;
`ifdef ARB_FIXED_PRIORITY_EN
        if (fft_req)      w_win = ID_FFT;
        else if (fir_req) w_win = ID_FIR;
        else if (iir_req) w_win = ID_IIR;
`else
        // Search begins at the accelerator after the previous owner.
        case (r_last)
            ID_FFT: begin
                if (fir_req)      w_win = ID_FIR;
                else if (iir_req) w_win = ID_IIR;
                else if (fft_req) w_win = ID_FFT;
            end
            ID_FIR: begin
                if (iir_req)      w_win = ID_IIR;
                else if (fft_req) w_win = ID_FFT;
                else if (fir_req) w_win = ID_FIR;
            end
            default: begin
                if (fft_req)      w_win = ID_FFT;
                else if (fir_req) w_win = ID_FIR;
                else if (iir_req) w_win = ID_IIR;
            end
        endcase
`endif
    end

    always_comb begin
        w_own_req = 1'b0;
        w_other   = 1'b0;
        case (r_gid)
            ID_FFT: begin
                w_own_req = fft_req;
`ifdef ARB_FIXED_PRIORITY_EN
                w_other   = 1'b0;
`else
                w_other   = fir_req | iir_req;
`endif
            end
            ID_FIR: begin
                w_own_req = fir_req;
`ifdef ARB_FIXED_PRIORITY_EN
                w_other   = fft_req;
`else
                w_other   = fft_req | iir_req;
`endif
            end
            ID_IIR: begin
                w_own_req = iir_req;
                w_other   = fft_req | fir_req;
            end
            default: begin
                w_own_req = 1'b0;
                w_other   = 1'b0;
            end
        endcase
    end

    assign w_qend = (r_qcnt == Q_LAST);
    assign w_rel  = !w_own_req || (w_qend && w_other);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_gid   <= ID_NONE;
            r_last  <= ID_IIR;
            r_en    <= 3'b000;
            r_qcnt  <= 8'd0;
            r_tcnt  <= 4'd0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_win != ID_NONE) begin
                        r_state <= S_GRANT;
                        r_gid   <= w_win;
                        r_last  <= w_win;
                        r_en    <= {w_win == ID_IIR, w_win == ID_FIR,
                                    w_win == ID_FFT};
                        r_qcnt  <= 8'd0;
                    end
                end
                S_GRANT: begin
                    if (!bus_busy && w_rel) begin
                        r_state <= S_TURN;
                        r_gid   <= ID_NONE;
                        r_en    <= 3'b000;
                        r_pulse <= 1'b1;
                        r_tcnt  <= 4'd0;
                    end else if (w_qend) begin
                        // Held by bus_busy: saturate; unopposed: new quantum.
                        r_qcnt <= w_other ? r_qcnt : 8'd0;
                    end else begin
                        r_qcnt <= r_qcnt + 8'd1;
                    end
                end
                S_TURN: begin
                    if (r_tcnt == T_LAST) r_state <= S_IDLE;
                    else r_tcnt <= r_tcnt + 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fft_enable    = r_en[0];
    assign fir_enable    = r_en[1];
    assign iir_enable    = r_en[2];
    assign grant_id      = r_gid;
    assign release_pulse = r_pulse;

endmodule

// File: tb/tb_accel_bus_arbiter.sv
// Scoreboard bench for accel_bus_arbiter (default round-robin build).
// Expected per-cycle outputs are hand-derived timelines.
module tb_accel_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       fft_req, fir_req, iir_req, bus_busy;
    logic       fft_enable, fir_enable, iir_enable;
    logic [1:0] grant_id;
    logic       release_pulse;

    int n_chk = 0;
    int n_err = 0;
    bit done  = 1'b0;

    typedef struct {
        logic [5:0] v;
        string      nm;
    } exp_t;
    exp_t q[$];

    // {iir_en, fir_en, fft_en, grant_id, release_pulse}
    localparam logic [5:0] E_NONE = 6'b000_00_0;
    localparam logic [5:0] E_PUL  = 6'b000_00_1;
    localparam logic [5:0] E_FFT  = 6'b001_01_0;
    localparam logic [5:0] E_FIR  = 6'b010_10_0;
    localparam logic [5:0] E_IIR  = 6'b100_11_0;

    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_FFT  = 3'b001;
    localparam logic [2:0] R_FIR  = 3'b010;
    localparam logic [2:0] R_IIR  = 3'b100;
    localparam logic [2:0] R_FF   = 3'b011;
    localparam logic [2:0] R_ALL  = 3'b111;

    accel_bus_arbiter #(.QUANTUM(16), .TURN_CYCLES(1)) dut (
        .clk(clk),
        .reset(reset),
        .fft_req(fft_req),
        .fir_req(fir_req),
        .iir_req(iir_req),
        .bus_busy(bus_busy),
        .fft_enable(fft_enable),
        .fir_enable(fir_enable),
        .iir_enable(iir_enable),
        .grant_id(grant_id),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {iir_enable, fir_enable, fft_enable, grant_id, release_pulse};
    endfunction

    task automatic check(input string nm, input logic [5:0] got,
                         input logic [5:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%b exp=%b t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic [2:0] req, input logic bb,
                       input logic [5:0] e, input string nm);
        exp_t x;
        @(negedge clk);
        {iir_req, fir_req, fft_req} = req;
        bus_busy = bb;
        x.v  = e;
        x.nm = nm;
        q.push_back(x);
    endtask

    task automatic seg(input int n, input logic [2:0] req, input logic bb,
                       input logic [5:0] e, input string nm);
        for (int i = 0; i < n; i++) cyc(req, bb, e, nm);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                x = q.pop_front();
                check(x.nm, outs(), x.v);
            end
        end
    end

    initial begin : stim
        reset    = 1'b0;
        fft_req  = 1'b0;
        fir_req  = 1'b0;
        iir_req  = 1'b0;
        bus_busy = 1'b0;
        #1;
        check("reset_state", outs(), E_NONE);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // All requesting: FFT -> FIR -> IIR -> FFT, 16 cycles each
        seg(16, R_ALL, 1'b0, E_FFT, "rr_fft");
        cyc(R_ALL, 1'b0, E_PUL, "rr_rel1");
        cyc(R_ALL, 1'b0, E_NONE, "rr_turn1");
        seg(16, R_ALL, 1'b0, E_FIR, "rr_fir");
        cyc(R_ALL, 1'b0, E_PUL, "rr_rel2");
        cyc(R_ALL, 1'b0, E_NONE, "rr_turn2");
        seg(16, R_ALL, 1'b0, E_IIR, "rr_iir");
        cyc(R_ALL, 1'b0, E_PUL, "rr_rel3");
        cyc(R_ALL, 1'b0, E_NONE, "rr_turn3");
        cyc(R_ALL, 1'b0, E_FFT, "rr_wrap_fft");
        cyc(R_NONE, 1'b0, E_PUL, "drop_rel");
        cyc(R_NONE, 1'b0, E_NONE, "drop_turn");
        cyc(R_NONE, 1'b0, E_NONE, "idle_none");

        // Sole FIR requester keeps the bus across quantum wraps
        seg(100, R_FIR, 1'b0, E_FIR, "sole_fir");
        cyc(R_NONE, 1'b0, E_PUL, "fir_rel");
        cyc(R_NONE, 1'b0, E_NONE, "fir_turn");

        // bus_busy holds FFT past its quantum
        cyc(R_FFT, 1'b0, E_FFT, "busy_g0");
        seg(13, R_FF, 1'b0, E_FFT, "busy_pre");
        seg(7, R_FF, 1'b1, E_FFT, "busy_hold");
        cyc(R_FF, 1'b0, E_PUL, "busy_rel");
        cyc(R_FF, 1'b0, E_NONE, "busy_turn");
        cyc(R_FF, 1'b0, E_FIR, "busy_next_fir");
        cyc(R_NONE, 1'b0, E_PUL, "fir2_rel");
        cyc(R_NONE, 1'b0, E_NONE, "fir2_turn");

        // IIR request glitch: release, TURN, re-grant
        seg(5, R_IIR, 1'b0, E_IIR, "iir_grant");
        cyc(R_NONE, 1'b0, E_PUL, "iir_glitch_rel");
        cyc(R_IIR, 1'b0, E_NONE, "iir_turn");
        seg(3, R_IIR, 1'b0, E_IIR, "iir_regrant");
        cyc(R_NONE, 1'b0, E_PUL, "iir_rel2");
        cyc(R_FFT, 1'b0, E_NONE, "turn_ignores_req");
        cyc(R_NONE, 1'b0, E_NONE, "idle_after_turn");
        cyc(R_NONE, 1'b0, E_NONE, "idle_quiet");

        // Asynchronous reset mid-grant
        seg(4, R_FFT, 1'b0, E_FFT, "pre_reset_fft");
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", outs(), E_NONE);
        seg(3, R_FFT, 1'b0, E_NONE, "in_reset");
        @(negedge clk);
        reset = 1'b1;
        cyc(R_FFT, 1'b0, E_FFT, "post_reset_fft");
        cyc(R_NONE, 1'b0, E_PUL, "post_reset_rel");
        cyc(R_NONE, 1'b0, E_NONE, "post_reset_turn");

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got=%0d pending exp=0", q.size());
        end
        done = 1'b1;
    end

    initial begin : finisher
        wait (done);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/accel_bus_arbiter.md
ACCEL_BUS_ARBITER -- requirements
Module: accel_bus_arbiter

Interface
REQ-001 Parameter QUANTUM, default 16, max cycles a grant is held while another accelerator requests (range 2..255).
REQ-002 Parameter TURN_CYCLES, default 1, bus-turnaround idle cycles between grants (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 fft_req, fir_req, iir_req  input  1 each  accelerator has data to move over the shared RAM bus.
REQ-006 bus_busy  input  1  RAM transfer in flight (ram_read_enable OR ram_write_enable of the data bus controller).
REQ-007 fft_enable, fir_enable, iir_enable  output  1 each  registered grant to the data bus controller; at most one high.
REQ-008 grant_id  output  2  00 none, 01 FFT, 10 FIR, 11 IIR; registered, consistent with enables.
REQ-009 release_pulse  output  1  one-cycle pulse on the cycle a grant is dropped.

Function
REQ-010 States: IDLE, GRANT, TURN; 8-bit quantum counter; 4-bit turn counter; 2-bit last-owner pointer.
REQ-011 IDLE: all enables 0; if any req high at a rising edge, next state GRANT with winner's enable and grant_id high from that edge (1-cycle latency).
REQ-012 Arbitration: round-robin; search order starts at the accelerator after last owner (FFT->FIR->IIR->FFT); first requester wins.
REQ-013 On entering GRANT: quantum counter = 0, last owner = winner.
REQ-014 GRANT: quantum counter increments each cycle, saturating at QUANTUM-1.
REQ-015 Release condition: owner's req low, OR (counter == QUANTUM-1 AND another req high).
REQ-016 Release only when bus_busy low; while bus_busy high grant is held regardless of release condition.
REQ-017 Counter == QUANTUM-1 with no other requester: grant held, counter reset to 0.
REQ-018 On release: enables 0, grant_id 00, release_pulse 1 for one cycle, next state TURN, turn counter = 0.
REQ-019 TURN: enables 0 for exactly TURN_CYCLES cycles, then IDLE; requests ignored during TURN.
REQ-020 Minimum gap between two grants = TURN_CYCLES + 1 cycles (TURN plus IDLE arbitration edge).
REQ-021 Request dropped and re-raised within TURN: no effect; arbitration uses values sampled in IDLE.
REQ-022 Enables never change while bus_busy high except via reset.
REQ-023 Enables and grant_id are driven directly from flops; no combinational input-to-output path.

Reset
REQ-024 reset low asynchronously forces: state IDLE, all enables 0, grant_id 00, release_pulse 0, counters 0, last owner = IIR (so FFT is searched first).
REQ-025 Reset asserted mid-grant or mid-TURN drops enables immediately, without release_pulse.
REQ-026 After reset release, first arbitration occurs on the first rising edge with reset high.

Configuration
REQ-027 Macro ARB_FIXED_PRIORITY_EN: when defined, REQ-012 replaced by fixed priority FFT > FIR > IIR, and REQ-015 quantum preemption applies only when a higher-priority req is high.
REQ-028 Without ARB_FIXED_PRIORITY_EN: round-robin per REQ-012 and REQ-015; last-owner pointer present.

Verification
REQ-029 Reset, all req high, bus_busy 0, QUANTUM 16 -> FFT 16 cycles, 1 idle TURN cycle + 1 IDLE, FIR 16, gap, IIR 16, gap, FFT; release_pulse at each switch.
REQ-030 Only fir_req high 100 cycles -> fir_enable high continuously after 1-cycle latency, no release_pulse.
REQ-031 FFT granted, fir_req high, bus_busy high cycles 14..20 of grant -> fft_enable held until bus_busy falls, released next edge.
REQ-032 iir_req pulses low for 1 cycle during grant -> release, TURN 1 cycle, IDLE; iir re-granted if sole requester.
REQ-033 reset driven low mid-grant between clock edges -> all enables and grant_id 00 immediately, release_pulse 0.
REQ-034 ARB_FIXED_PRIORITY_EN defined, fir/iir req high, FFT raised at FIR cycle 5 -> FIR held to quantum expiry, then FFT granted, IIR starves while FFT/FIR request.
